wbs_ctrl: RTL and testbench



---
 rtl/wbs_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_wbs_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbs_ctrl.sv
// Wishbone slave for the ANN accelerator debug/config port: control registers plus query, leaf, best-match and node windows.
// Define WBS_SEL_MASK_EN to make register writes and the holding-register load honour wbs_sel_i byte enables.
module wbs_ctrl #(
    parameter int DATA_WIDTH = 11,
    parameter int LEAF_SIZE  = 8,
    parameter int PATCH_SIZE = 5,
    parameter int ROW_SIZE   = 24,
    parameter int COL_SIZE   = 17,
    parameter int K          = 4,
    parameter int NUM_LEAVES = 64,
    localparam int QADDRW     = $clog2(ROW_SIZE * COL_SIZE),
    localparam int LEAF_ADDRW = $clog2(NUM_LEAVES),
    localparam int BANKW      = $clog2(LEAF_SIZE),
    localparam int PATCHW     = PATCH_SIZE * DATA_WIDTH
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_dat_i,
    input  logic [31:0]           wbs_adr_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_dat_o,
    output logic                  wbs_mode,
    output logic                  wbs_debug,
    output logic                  wbs_qp_mem_csb0,
    output logic                  wbs_qp_mem_web0,
    output logic [QADDRW-1:0]     wbs_qp_mem_addr0,
    output logic [PATCHW-1:0]     wbs_qp_mem_wpatch0,
    input  logic [PATCHW-1:0]     wbs_qp_mem_rpatch0,
    output logic [LEAF_SIZE-1:0]  wbs_leaf_mem_csb0,
    output logic [LEAF_SIZE-1:0]  wbs_leaf_mem_web0,
    output logic [LEAF_ADDRW-1:0] wbs_leaf_mem_addr0,
    output logic [63:0]           wbs_leaf_mem_wleaf0,
    input  logic [63:0]           wbs_leaf_mem_rleaf0 [LEAF_SIZE],
    output logic                  wbs_node_mem_web,
    output logic [31:0]           wbs_node_mem_addr,
    output logic [31:0]           wbs_node_mem_wdata,
    input  logic [31:0]           wbs_node_mem_rdata,
    output logic                  wbs_best_arr_csb1,
    output logic [7:0]            wbs_best_arr_addr1,
    input  logic [63:0]           wbs_best_arr_rdata1,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_ACK} state_t;
    typedef enum logic [2:0] {RG_REG, RG_QUERY, RG_LEAF, RG_BEST, RG_NODE, RG_NONE} region_t;

    localparam logic [15:0] OFF_MODE  = 16'h0000;
    localparam logic [15:0] OFF_DEBUG = 16'h0004;

    function automatic region_t region_of(input logic [15:0] page);
        case (page)
            16'h3000: region_of = RG_REG;
            16'h3001: region_of = RG_QUERY;
            16'h3002: region_of = RG_LEAF;
            16'h3003: region_of = RG_BEST;
            16'h3004: region_of = RG_NODE;
            default:  region_of = RG_NONE;
        endcase
    endfunction

    state_t      state, state_next;
    logic [31:0] req_adr, req_dat, hold;
    logic        req_we;
    logic        start, reg_wr_en, reg_bit, in_req;
    logic [31:0] hold_next, rd_word;
    logic [63:0] wr_full, q_ext;
    region_t     in_region, req_region;
    logic [BANKW-1:0] bank;

    // Handshake: a transfer is requested while cyc&stb are high in IDLE; the master
    // holds its request until it sees wbs_ack_o (one cycle), then drops stb/cyc.
    assign start      = wbs_cyc_i & wbs_stb_i;
    assign in_region  = region_of(wbs_adr_i[31:16]);
    assign req_region = region_of(req_adr[31:16]);
    assign bank       = req_adr[3 +: BANKW];
    assign in_req     = (state == ST_REQ);

`ifdef WBS_SEL_MASK_EN
    always_comb begin
        hold_next = hold;
        for (int b = 0; b < 4; b++) begin
            if (wbs_sel_i[b]) hold_next[b*8 +: 8] = wbs_dat_i[b*8 +: 8];
        end
        reg_wr_en = wbs_sel_i[0];
    end
`else
    logic unused_sel;
    assign unused_sel = ^wbs_sel_i;
    assign hold_next  = wbs_dat_i;
    assign reg_wr_en  = 1'b1;
`endif

    always_comb begin
        reg_bit = 1'b0;
        case (wbs_adr_i[15:0])
            OFF_MODE:  reg_bit = wbs_mode;
            OFF_DEBUG: reg_bit = wbs_debug;
            default:   reg_bit = 1'b0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    case (in_region)
                        RG_QUERY, RG_LEAF: state_next = (wbs_we_i && !wbs_adr_i[2]) ? ST_ACK : ST_REQ;
                        RG_BEST:           state_next = wbs_we_i ? ST_ACK : ST_REQ;
                        RG_NODE:           state_next = ST_REQ;
                        default:           state_next = ST_ACK;
                    endcase
                end
            end
            ST_REQ:  state_next = req_we ? ST_ACK : ST_WAIT;
            ST_WAIT: state_next = ST_ACK;
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Read-return mux; QUERY patches are zero-extended to 64 bits before the half select.
    assign q_ext = 64'(wbs_qp_mem_rpatch0);
    always_comb begin
        rd_word = '0;
        case (req_region)
            RG_QUERY: rd_word = req_adr[2] ? q_ext[63:32] : q_ext[31:0];
            RG_LEAF:  rd_word = req_adr[2] ? wbs_leaf_mem_rleaf0[bank][63:32]
                                           : wbs_leaf_mem_rleaf0[bank][31:0];
            RG_BEST:  rd_word = req_adr[2] ? wbs_best_arr_rdata1[63:32] : wbs_best_arr_rdata1[31:0];
            RG_NODE:  rd_word = wbs_node_mem_rdata;
            default:  rd_word = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            req_adr   <= '0;
            req_dat   <= '0;
            req_we    <= 1'b0;
            hold      <= '0;
            wbs_dat_o <= '0;
            wbs_mode  <= 1'b0;
            wbs_debug <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                req_adr <= wbs_adr_i;
                req_dat <= wbs_dat_i;
                req_we  <= wbs_we_i;
                if (wbs_we_i) begin
                    if (in_region == RG_REG && reg_wr_en) begin
                        if (wbs_adr_i[15:0] == OFF_MODE)  wbs_mode  <= wbs_dat_i[0];
                        if (wbs_adr_i[15:0] == OFF_DEBUG) wbs_debug <= wbs_dat_i[0];
                    end
                    if ((in_region == RG_QUERY || in_region == RG_LEAF) && !wbs_adr_i[2])
                        hold <= hold_next;
                end else if (in_region == RG_REG) begin
                    wbs_dat_o <= {31'b0, reg_bit};
                end else if (in_region == RG_NONE) begin
                    wbs_dat_o <= '0;
                end
            end
            if (state == ST_WAIT) wbs_dat_o <= rd_word;
        end
    end

    // Strobes are live only during REQ; addresses and write data come from the captured request.
    assign wr_full             = {req_dat, hold};
    assign wbs_qp_mem_csb0     = !(in_req && req_region == RG_QUERY);
    assign wbs_qp_mem_web0     = !(in_req && req_region == RG_QUERY && req_we);
    assign wbs_qp_mem_addr0    = req_adr[3 +: QADDRW];
    assign wbs_qp_mem_wpatch0  = wr_full[PATCHW-1:0];
    assign wbs_leaf_mem_csb0   = (in_req && req_region == RG_LEAF) ? ~(LEAF_SIZE'(1) << bank) : '1;
    assign wbs_leaf_mem_web0   = (in_req && req_region == RG_LEAF && req_we) ? ~(LEAF_SIZE'(1) << bank) : '1;
    assign wbs_leaf_mem_addr0  = req_adr[3 + BANKW +: LEAF_ADDRW];
    assign wbs_leaf_mem_wleaf0 = wr_full;
    assign wbs_node_mem_web    = in_req && req_region == RG_NODE && req_we;
    assign wbs_node_mem_addr   = {16'b0, req_adr[15:0]};
    assign wbs_node_mem_wdata  = req_dat;
    assign wbs_best_arr_csb1   = !(in_req && req_region == RG_BEST);
    assign wbs_best_arr_addr1  = req_adr[10:3];
    assign wbs_ack_o           = (state == ST_ACK);
    assign fsm_state           = state;

endmodule

// File: tb/tb_wbs_ctrl.sv
// Directed bench for wbs_ctrl: drivers issue Wishbone transfers, monitors score acks and memory strobes.
module tb_wbs_ctrl;

  localparam logic [2:0] K_QP = 3'd1, K_LEAF = 3'd2, K_BEST = 3'd3, K_NODE = 3'd4;

  typedef struct packed {
    logic [2:0]  kind;
    logic        we;
    logic [7:0]  lcsb;
    logic [7:0]  lweb;
    logic [31:0] addr;
    logic [63:0] data;
  } strobe_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] dat_i = '0, adr = '0;
  logic        ack;
  logic [31:0] dat_o;
  logic        mode, debug;
  logic        qp_csb, qp_web;
  logic [8:0]  qp_addr;
  logic [54:0] qp_wpatch, qp_rpatch;
  logic [7:0]  leaf_csb, leaf_web;
  logic [5:0]  leaf_addr;
  logic [63:0] leaf_wleaf;
  logic [63:0] leaf_rleaf [8];
  logic        node_web;
  logic [31:0] node_addr, node_wdata, node_rdata;
  logic        best_csb;
  logic [7:0]  best_addr;
  logic [63:0] best_rdata;
  logic [1:0]  fsm_state;

  logic [33:0] exp_q[$];
  strobe_t     strobe_q[$];
  logic [31:0] node_mem [256];
  int          checks = 0;
  int          errors = 0;
  logic        m_mode = 1'b0, m_dbg = 1'b0;
  logic [31:0] m_dat = '0;
  logic        prev_ack = 1'b0;

  wbs_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .wbs_mode(mode), .wbs_debug(debug),
    .wbs_qp_mem_csb0(qp_csb), .wbs_qp_mem_web0(qp_web), .wbs_qp_mem_addr0(qp_addr),
    .wbs_qp_mem_wpatch0(qp_wpatch), .wbs_qp_mem_rpatch0(qp_rpatch),
    .wbs_leaf_mem_csb0(leaf_csb), .wbs_leaf_mem_web0(leaf_web), .wbs_leaf_mem_addr0(leaf_addr),
    .wbs_leaf_mem_wleaf0(leaf_wleaf), .wbs_leaf_mem_rleaf0(leaf_rleaf),
    .wbs_node_mem_web(node_web), .wbs_node_mem_addr(node_addr),
    .wbs_node_mem_wdata(node_wdata), .wbs_node_mem_rdata(node_rdata),
    .wbs_best_arr_csb1(best_csb), .wbs_best_arr_addr1(best_addr), .wbs_best_arr_rdata1(best_rdata),
    .fsm_state(fsm_state)
  );

  // Clock and node-memory model
  always #5 clk = ~clk;

  always @(posedge clk) if (node_web) node_mem[node_addr[7:0]] <= node_wdata;
  assign node_rdata = node_mem[node_addr[7:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_strobe(input logic [2:0] kind, input logic w, input logic [7:0] lcsb,
                            input logic [7:0] lweb, input logic [31:0] a, input logic [63:0] d);
    strobe_t s;
    s.kind = kind; s.we = w; s.lcsb = lcsb; s.lweb = lweb; s.addr = a; s.data = d;
    strobe_q.push_back(s);
  endtask

  // Driver: one Wishbone transfer; the caller updates m_mode/m_dbg, reads pass the expected word
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rd_exp);
    bit got;
    int n;
    if (!w) m_dat = rd_exp;
    exp_q.push_back({m_mode, m_dbg, m_dat});
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d;
    got = 0;
    n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (ack) got = 1;
      n++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: adr %h got no ack expected ack within 20 cycles", a);
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  // Monitor: ack pulses against the expected queue, strobes against the strobe queue
  always @(negedge clk) begin
    logic [33:0] e;
    strobe_t s, a;
    if (ack) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: got ack expected none (dat_o %h)", dat_o);
      end else begin
        e = exp_q.pop_front();
        if ({mode, debug, dat_o} !== e) begin
          errors++;
          $display("FAIL ack_state: got mode/debug/dat %h expected %h", {mode, debug, dat_o}, e);
        end
      end
      checks++;
      if (prev_ack) begin
        errors++;
        $display("FAIL ack_pulse: got ack high 2 cycles expected 1");
      end
    end
    prev_ack = ack;

    if (!qp_csb || !qp_web || leaf_csb != 8'hFF || leaf_web != 8'hFF || !best_csb || node_web) begin
      a = '0;
      a.lcsb = leaf_csb;
      a.lweb = leaf_web;
      if (!qp_csb || !qp_web) begin
        a.kind = K_QP; a.we = !qp_web; a.addr = 32'(qp_addr);
        a.data = a.we ? 64'(qp_wpatch) : 64'h0;
      end else if (leaf_csb != 8'hFF || leaf_web != 8'hFF) begin
        a.kind = K_LEAF; a.we = (leaf_web != 8'hFF); a.addr = 32'(leaf_addr);
        a.data = a.we ? leaf_wleaf : 64'h0;
      end else if (!best_csb) begin
        a.kind = K_BEST; a.we = 1'b0; a.addr = 32'(best_addr);
      end else begin
        a.kind = K_NODE; a.we = 1'b1; a.addr = node_addr; a.data = 64'(node_wdata);
      end
      checks++;
      if (strobe_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got %h expected no strobe", a);
      end else begin
        s = strobe_q.pop_front();
        if (a !== s) begin
          errors++;
          $display("FAIL strobe: got %h expected %h", a, s);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within 500us");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) node_mem[i] = '0;
    for (int i = 0; i < 8; i++) leaf_rleaf[i] = 64'hA5A5_0000_5A5A_0000 | 64'(i);
    leaf_rleaf[7] = 64'h1100_1010_DEADBEEF;
    leaf_rleaf[0] = 64'h0123_4567_89AB_CDEF;
    qp_rpatch  = 55'h00_1010_DEADBEEF;
    best_rdata = 64'h1100_1010_DEADBEEF;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", 64'(ack), 64'h0);
    chk("rst_dat", 64'(dat_o), 64'h0);
    chk("rst_mode_debug", 64'({mode, debug}), 64'h0);
    chk("rst_qp_strobes", 64'({qp_csb, qp_web, best_csb, node_web}), 64'hE);
    chk("rst_leaf_strobes", 64'({leaf_csb, leaf_web}), 64'hFFFF);
    chk("rst_state", 64'(fsm_state), 64'h0);

    // Control registers
    m_dbg = 1'b1;  wb_xfer(1, 32'h3000_0004, 32'h1, 0);
    m_mode = 1'b1; wb_xfer(1, 32'h3000_0000, 32'h1, 0);
    m_dbg = 1'b0;  wb_xfer(1, 32'h3000_0004, 32'h0, 0);
    wb_xfer(0, 32'h3000_0000, 0, 32'h1);
    wb_xfer(1, 32'h3000_0008, 32'h1, 0);
    wb_xfer(0, 32'h3000_0008, 0, 32'h0);
    wb_xfer(1, 32'h3000_0004, 32'hFFFF_FFFE, 0);
    wb_xfer(0, 32'h3000_0004, 0, 32'h0);
    wb_xfer(0, 32'h3000_0000, 0, 32'h1);

    // Query SRAM
    exp_strobe(K_QP, 0, 8'hFF, 8'hFF, 1, 64'h0);
    wb_xfer(0, 32'h3001_0008, 0, 32'hDEADBEEF);
    exp_strobe(K_QP, 0, 8'hFF, 8'hFF, 1, 64'h0);
    wb_xfer(0, 32'h3001_000C, 0, 32'h0000_1010);
    wb_xfer(1, 32'h3001_0010, 32'h0123_4567, 0);
    exp_strobe(K_QP, 1, 8'hFF, 8'hFF, 2, 64'h000B_CDEF_0123_4567);
    wb_xfer(1, 32'h3001_0014, 32'h000B_CDEF, 0);
    wb_xfer(1, 32'h3001_0CF8, 32'hCAFE_F00D, 0);
    exp_strobe(K_QP, 1, 8'hFF, 8'hFF, 32'h19F, 64'h007F_FFFF_CAFE_F00D);
    wb_xfer(1, 32'h3001_0CFC, 32'hFFFF_FFFF, 0);

    // Leaf SRAM banks
    exp_strobe(K_LEAF, 0, 8'h7F, 8'hFF, 0, 64'h0);
    wb_xfer(0, 32'h3002_0038, 0, 32'hDEADBEEF);
    exp_strobe(K_LEAF, 0, 8'h7F, 8'hFF, 0, 64'h0);
    wb_xfer(0, 32'h3002_003C, 0, 32'h1100_1010);
    wb_xfer(0, 32'h3000_000C, 0, 32'h0);
    exp_strobe(K_LEAF, 0, 8'hFE, 8'hFF, 0, 64'h0);
    wb_xfer(0, 32'h3002_0000, 0, 32'h89AB_CDEF);
    wb_xfer(1, 32'h3002_0FC8, 32'h1111_1111, 0);
    exp_strobe(K_LEAF, 1, 8'hFD, 8'hFD, 63, 64'h2222_2222_1111_1111);
    wb_xfer(1, 32'h3002_0FCC, 32'h2222_2222, 0);

    // Best-match array, ignored write, unmapped page
    exp_strobe(K_BEST, 0, 8'hFF, 8'hFF, 7, 64'h0);
    wb_xfer(0, 32'h3003_0038, 0, 32'hDEADBEEF);
    exp_strobe(K_BEST, 0, 8'hFF, 8'hFF, 7, 64'h0);
    wb_xfer(0, 32'h3003_003C, 0, 32'h1100_1010);
    wb_xfer(1, 32'h3003_0000, 32'h1234_5678, 0);
    wb_xfer(0, 32'h3005_0000, 0, 32'h0);
    wb_xfer(1, 32'h3005_0000, 32'hFFFF_FFFF, 0);

    // Internal-node tree
    exp_strobe(K_NODE, 1, 8'hFF, 8'hFF, 1, 64'h0001_B801);
    wb_xfer(1, 32'h3004_0001, 32'h0001_B801, 0);
    wb_xfer(0, 32'h3004_0001, 0, 32'h0001_B801);
    exp_strobe(K_NODE, 1, 8'hFF, 8'hFF, 32'h3F, 64'h0001_5002);
    wb_xfer(1, 32'h3004_003F, 32'h0001_5002, 0);
    wb_xfer(0, 32'h3004_003F, 0, 32'h0001_5002);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("node_dat_held", 64'(dat_o), 64'h0001_5002);

    // Reset during a query read: strobe seen once, no ack, state cleared
    exp_strobe(K_QP, 0, 8'hFF, 8'hFF, 1, 64'h0);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3001_0008;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    m_mode = 1'b0; m_dbg = 1'b0; m_dat = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("midrst_state", 64'(fsm_state), 64'h0);
    chk("midrst_dat", 64'(dat_o), 64'h0);
    chk("midrst_mode", 64'({mode, debug}), 64'h0);

    wb_xfer(0, 32'h3000_0000, 0, 32'h0);
    exp_strobe(K_BEST, 0, 8'hFF, 8'hFF, 7, 64'h0);
    wb_xfer(0, 32'h3003_003C, 0, 32'h1100_1010);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'h0);
    chk("strobe_q_drained", 64'(strobe_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
